// File: rtl/llr_frame_packer.sv
// llr_frame_packer: quantizes soft samples to saturated LLRs and packs N_V of them into MSB-first bus words.
// Optional feature LLR_FRAME_PACKER_SAT_CNT_EN adds sat_count, the number of clamped samples in the last emitted frame.
`ifndef LLR_WIDTH
`define LLR_WIDTH 6
`endif
`ifndef N_V
`define N_V 4
`endif
module llr_frame_packer #(
  parameter int LLR_WIDTH    = `LLR_WIDTH,
  parameter int N_V          = `N_V,
  parameter int SAMPLE_WIDTH = 12,
  parameter int SHIFT        = 4,
  parameter int BUS_WIDTH    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SAMPLE_WIDTH-1:0] s_tdata,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  input  logic                    s_tlast,
  output logic [BUS_WIDTH-1:0]    m_tdata,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic                    m_tlast,
  output logic                    err_short,
  output logic                    err_long
`ifdef LLR_FRAME_PACKER_SAT_CNT_EN
  ,
  output logic [15:0]             sat_count
`endif
);
  localparam int FRAME_BITS = LLR_WIDTH * N_V;
  localparam int WORDS = (FRAME_BITS - 1) / BUS_WIDTH + 1;
  localparam int TOT = WORDS * BUS_WIDTH;
  localparam int IW = N_V > 1 ? $clog2(N_V) : 1;
  localparam int WW = WORDS > 1 ? $clog2(WORDS) : 1;
  localparam logic signed [SAMPLE_WIDTH-1:0] QMAX = SAMPLE_WIDTH'(2 ** (LLR_WIDTH - 1) - 1);
  localparam logic signed [SAMPLE_WIDTH-1:0] QMIN = -QMAX;
  typedef enum logic [1:0] {COLLECT, EMIT, DRAIN} state_t;
  state_t state;
  logic [IW-1:0] idx;
  logic [WW-1:0] wc;
  logic [FRAME_BITS-1:0] frame, frame_nx;
  logic drain_pend;
  logic signed [SAMPLE_WIDTH-1:0] q;
  logic [LLR_WIDTH-1:0] llr;
  logic sat, s_hs, last_idx, closing;
  function automatic logic [BUS_WIDTH-1:0] word_of(input logic [TOT-1:0] p, input int w);
    return p[(WORDS-1-w)*BUS_WIDTH +: BUS_WIDTH];
  endfunction
  assign q = $signed(s_tdata) >>> SHIFT;
  assign sat = q > QMAX || q < QMIN;
  assign llr = sat ? (q[SAMPLE_WIDTH-1] ? QMIN[LLR_WIDTH-1:0] : QMAX[LLR_WIDTH-1:0]) : q[LLR_WIDTH-1:0];
  assign s_hs = s_tvalid & s_tready;
  assign last_idx = int'(idx) == N_V - 1;
  assign closing = s_tlast | last_idx;
  // frame buffer with the current sample's LLR dropped into slot idx (LLR0 at the MSB end)
  always_comb begin
    frame_nx = frame;
    frame_nx[FRAME_BITS-1-int'(idx)*LLR_WIDTH -: LLR_WIDTH] = llr;
  end
  // frame state machine with registered handshake, data and error outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= COLLECT;
      idx        <= '0;
      wc         <= '0;
      frame      <= '0;
      drain_pend <= 1'b0;
      s_tready   <= 1'b0;
      m_tvalid   <= 1'b0;
      m_tlast    <= 1'b0;
      m_tdata    <= '0;
      err_short  <= 1'b0;
      err_long   <= 1'b0;
    end else begin
      err_short <= 1'b0;
      err_long  <= 1'b0;
      case (state)
        COLLECT: begin
          s_tready <= 1'b1;
          if (s_hs) begin
            frame <= frame_nx;
            idx   <= idx + 1'b1;
            if (closing) begin
              state      <= EMIT;
              s_tready   <= 1'b0;
              m_tvalid   <= 1'b1;
              m_tdata    <= word_of(TOT'(frame_nx), 0);
              m_tlast    <= WORDS == 1;
              wc         <= '0;
              err_short  <= s_tlast & ~last_idx;
              err_long   <= ~s_tlast;
              drain_pend <= ~s_tlast;
            end
          end
        end
        EMIT: begin
          if (m_tready) begin
            if (int'(wc) == WORDS - 1) begin
              state    <= drain_pend ? DRAIN : COLLECT;
              s_tready <= 1'b1;
              m_tvalid <= 1'b0;
              m_tlast  <= 1'b0;
              m_tdata  <= '0;
              wc       <= '0;
              idx      <= '0;
              frame    <= '0;
            end else begin
              wc      <= wc + 1'b1;
              m_tdata <= word_of(TOT'(frame), int'(wc) + 1);
              m_tlast <= int'(wc) + 1 == WORDS - 1;
            end
          end
        end
        DRAIN: begin
          s_tready <= 1'b1;
          if (s_hs && s_tlast) begin
            drain_pend <= 1'b0;
            state      <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end
`ifdef LLR_FRAME_PACKER_SAT_CNT_EN
  logic [15:0] sat_acc, sat_acc_nx;
  assign sat_acc_nx = &sat_acc ? sat_acc : sat_acc + 16'(sat);
  // count clamps within the frame and publish the total when word 0 goes out
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sat_acc   <= '0;
      sat_count <= '0;
    end else if (state == COLLECT && s_hs) begin
      sat_acc   <= closing ? '0 : sat_acc_nx;
      sat_count <= closing ? sat_acc_nx : sat_count;
    end
  end
`endif
endmodule
